// File: rtl/prog_prescaler_pkg.sv
// Shared constants and helpers for the programmable prescaler.
package prog_prescaler_pkg;

    localparam int DEF_WIDTH = 21;
    localparam int DEF_NCH   = 2;
    localparam int DEF_DIV   = 15;

    // Channel-select bus width; kept at one bit even for a single channel.
    function automatic int chan_sel_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/prescaler_chan.sv
// One prescaler channel: counter, divisor, clk_out and tick. With
// PROG_PRESCALER_GLITCHFREE_EN a shadow divisor commits at the next wrap or clr.
module prescaler_chan
    import prog_prescaler_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RST_DIV = DEF_DIV
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] val_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pending_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // The counter never passes the divisor, so the equality test is the only wrap rule.
    assign wrap = en_i && (cnt_q == div_q);

`ifdef PROG_PRESCALER_GLITCHFREE_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (clr_i) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            pend_d = 1'b0;
            if (wr_i) begin
                div_d = val_i;
            end else if (pend_q) begin
                div_d = shadow_q;
            end
        end else begin
            if (wrap) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (pend_q) begin
                    div_d  = shadow_q;
                    pend_d = 1'b0;
                end
            end else if (en_i) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            // A write landing on a wrap only arms the shadow for the following wrap.
            if (wr_i) begin
                shadow_d = val_i;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= WIDTH'(RST_DIV);
            pend_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end

    assign pending_o = pend_q;
`else
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (wr_i) begin
                div_d = val_i;
            end
        end else if (wr_i) begin
            div_d = val_i;
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    assign pending_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            div_q  <= WIDTH'(RST_DIV);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/prog_prescaler.sv
// Multi-channel programmable clock prescaler. Define PROG_PRESCALER_GLITCHFREE_EN
// to defer divisor writes to the next half-period boundary.
module prog_prescaler
    import prog_prescaler_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NCH     = DEF_NCH,
    parameter int DEF_DIV = prog_prescaler_pkg::DEF_DIV
) (
    input  logic                           clk_in,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           clr,
    input  logic                           div_wr,
    input  logic [chan_sel_width(NCH)-1:0] div_sel,
    input  logic [WIDTH-1:0]               div_val,
    output logic [NCH-1:0]                 clk_out,
    output logic [NCH-1:0]                 tick,
    output logic [NCH-1:0]                 pending
);

    localparam int SW = chan_sel_width(NCH);

    // Selects at or above NCH match no channel, so such writes vanish.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic wrSel;

        assign wrSel = div_wr && (div_sel == SW'(g));

        prescaler_chan #(
            .WIDTH   (WIDTH),
            .RST_DIV (DEF_DIV)
        ) u_chan (
            .clk_i     (clk_in),
            .rst_ni    (rst_n),
            .en_i      (en),
            .clr_i     (clr),
            .wr_i      (wrSel),
            .val_i     (div_val),
            .clk_out_o (clk_out[g]),
            .tick_o    (tick[g]),
            .pending_o (pending[g])
        );
    end

endmodule
